// File: rtl/mining_ctrl_param.sv
// Nonce-search controller: streams message chunks to a hash core,
// patches the nonce into the last chunk and checks leading-zero difficulty.
module mining_ctrl_param #(
  parameter int CHUNK_W   = 512,
  parameter int ADDR_W    = 16,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256,
  parameter int NONCE_POS = 511,
  parameter int DIFF_W    = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic [ADDR_W-1:0]  n_chunks,
  input  logic [DIFF_W-1:0]  difficulty,
  input  logic [CHUNK_W-1:0] mem_rd_data,
  input  logic               chunk_ready,
  input  logic [HASH_W-1:0]  hash_in,
  input  logic               hash_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_n,
  output logic [CHUNK_W-1:0] chunk_out,
  output logic               chunk_valid,
  output logic               chunk_last,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic               done,
  output logic [NONCE_W-1:0] nonce_out,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0]  nch_q, nch_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] nend_q, nend_d;
  logic [DIFF_W-1:0]  diff_q, diff_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic               rd_n_q, rd_n_d;
  logic               cvalid_q, cvalid_d;
  logic               clast_q, clast_d;
  logic               found_q, found_d;
  logic               exh_q, exh_d;
  logic               done_q, done_d;

  logic               is_last;
  logic               hit;
  logic [31:0]        diff_ext;

  assign is_last  = (idx_q == nch_q - ADDR_W'(1));
  assign diff_ext = 32'(diff_q);

  // Hit when the top diff_q hash bits are zero; diff >= HASH_W needs all zero.
  always_comb begin
    hit = 1'b1;
    for (int i = 0; i < HASH_W; i++) begin
      if (($unsigned(i) < diff_ext) && hash_q[HASH_W-1-i]) begin
        hit = 1'b0;
      end
    end
  end

  // Next-state logic for the search FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nch_d    = nch_q;
    addr_d   = addr_q;
    nonce_d  = nonce_q;
    nend_d   = nend_q;
    diff_d   = diff_q;
    hash_d   = hash_q;
    chunk_d  = chunk_q;
    rd_n_d   = rd_n_q;
    cvalid_d = cvalid_q;
    clast_d  = clast_q;
    found_d  = 1'b0;
    exh_d    = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nend_d  = nonce_end;
          diff_d  = difficulty;
          nch_d   = (n_chunks == '0) ? ADDR_W'(1) : n_chunks;
          nonce_d = nonce_start;
          idx_d   = '0;
          if (nonce_start > nonce_end) begin
            exh_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            addr_d  = '0;
            rd_n_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        rd_n_d  = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        chunk_d = mem_rd_data;
        if (is_last) begin
          chunk_d[NONCE_POS -: NONCE_W] = nonce_q;
        end
        cvalid_d = 1'b1;
        clast_d  = is_last;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (chunk_ready) begin
          cvalid_d = 1'b0;
          clast_d  = 1'b0;
          if (clast_q) begin
            state_d = S_WAIT;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            addr_d  = idx_q + ADDR_W'(1);
            rd_n_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_WAIT: begin
        if (hash_valid) begin
          hash_d  = hash_in;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          found_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else if (nonce_q == nend_q) begin
          exh_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          nonce_d = nonce_q + NONCE_W'(1);
          idx_d   = '0;
          addr_d  = '0;
          rd_n_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      cvalid_d = 1'b0;
      clast_d  = 1'b0;
      rd_n_d   = 1'b1;
      found_d  = 1'b0;
      exh_d    = 1'b0;
      done_d   = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      nch_q    <= '0;
      addr_q   <= '0;
      nonce_q  <= '0;
      nend_q   <= '0;
      diff_q   <= '0;
      hash_q   <= '0;
      chunk_q  <= '0;
      rd_n_q   <= 1'b1;
      cvalid_q <= 1'b0;
      clast_q  <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nch_q    <= nch_d;
      addr_q   <= addr_d;
      nonce_q  <= nonce_d;
      nend_q   <= nend_d;
      diff_q   <= diff_d;
      hash_q   <= hash_d;
      chunk_q  <= chunk_d;
      rd_n_q   <= rd_n_d;
      cvalid_q <= cvalid_d;
      clast_q  <= clast_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      done_q   <= done_d;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q != S_IDLE);
  assign mem_addr    = addr_q;
  assign mem_rd_n    = rd_n_q;
  assign chunk_out   = chunk_q;
  assign chunk_valid = cvalid_q;
  assign chunk_last  = clast_q;
  assign found       = found_q;
  assign exhausted   = exh_q;
  assign done        = done_q;
  assign nonce_out   = nonce_q;

endmodule

// File: tb/tb_mining_ctrl_param.sv
// Bench for mining_ctrl_param: memory and hash-core responders,
// a search-level result model and a per-cycle output checker.
module tb_mining_ctrl_param;

  logic         clock;
  logic         reset;
  logic         start;
  logic         abort;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [15:0]  n_chunks;
  logic [8:0]   difficulty;
  logic [511:0] mem_rd_data;
  logic         chunk_ready;
  logic [255:0] hash_in;
  logic         hash_valid;
  logic [15:0]  mem_addr;
  logic         mem_rd_n;
  logic [511:0] chunk_out;
  logic         chunk_valid;
  logic         chunk_last;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic         done;
  logic [31:0]  nonce_out;
  logic [2:0]   state;

  mining_ctrl_param dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .n_chunks(n_chunks), .difficulty(difficulty),
    .mem_rd_data(mem_rd_data), .chunk_ready(chunk_ready),
    .hash_in(hash_in), .hash_valid(hash_valid),
    .mem_addr(mem_addr), .mem_rd_n(mem_rd_n),
    .chunk_out(chunk_out), .chunk_valid(chunk_valid),
    .chunk_last(chunk_last), .busy(busy), .found(found),
    .exhausted(exhausted), .done(done),
    .nonce_out(nonce_out), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // environment configuration
  logic [511:0] mem [0:7];
  int           hit_mode;
  logic [31:0]  hit_n;
  int           rdy_delay;
  int           hash_delay;

  function automatic logic [255:0] hashf(input logic [31:0] n);
    if (hit_mode == 1 && n == hit_n) return {16'h0020, 208'h0, n};
    if (hit_mode == 2 && n == hit_n) return '0;
    return {16'h0040, 208'h0, n};
  endfunction

  function automatic bit is_hit(input logic [255:0] h, input int d);
    int lz;
    if (d >= 256) return (h == '0);
    lz = 0;
    for (int i = 255; i >= 0; i--) begin
      if (h[i]) break;
      lz++;
    end
    return lz >= d;
  endfunction

  // chunk memory: data valid the cycle after a read strobe
  always @(posedge clock) begin
    if (!mem_rd_n && mem_addr < 16'd8)
      mem_rd_data <= mem[mem_addr[2:0]];
    else
      mem_rd_data <= {16{32'hDEADBEEF}};
  end

  // hash core: ready after rdy_delay cycles, digest hash_delay later
  int          rcnt, hcnt;
  bit          pend, r_give, r_give_last;
  logic [31:0] r_nonce;
  logic [255:0] phash;
  always @(negedge clock) begin
    if (!reset) begin
      chunk_ready = 1'b0;
      hash_valid  = 1'b0;
      hash_in     = '0;
      rcnt = 0;
      pend = 1'b0;
      r_give = 1'b0;
    end else begin
      hash_valid = 1'b0;
      if (r_give && r_give_last) begin
        pend  = 1'b1;
        hcnt  = hash_delay;
        phash = hashf(r_nonce);
      end
      if (chunk_valid) begin
        if (rcnt < rdy_delay) begin
          chunk_ready = 1'b0;
          rcnt++;
        end else begin
          chunk_ready = 1'b1;
        end
      end else begin
        chunk_ready = 1'b0;
        rcnt = 0;
      end
      r_give      = chunk_valid && chunk_ready;
      r_give_last = chunk_last;
      r_nonce     = chunk_out[511:480];
      if (pend) begin
        if (hcnt == 0) begin
          hash_valid = 1'b1;
          hash_in    = phash;
          pend       = 1'b0;
        end else begin
          hcnt--;
        end
      end
    end
  end

  // search-level model
  logic [31:0] m_start, m_nonce;
  int          m_nch, m_count;
  bit          m_found, m_exh;

  // observation state
  bit           prev_cv, prev_last;
  logic [511:0] prev_chunk, exp_c, last_acc_chunk;
  int           cur_idx, tested, reads, found_cnt, pres, last_pres;
  int           busy_cnt;
  bit           done_seen, armed, last_found, last_exh;
  logic [31:0]  last_nonce;

  // per-cycle compare against the model
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      prev_cv = 1'b0;
      prev_last = 1'b0;
      pres = 0;
    end else begin
      chk("busy", busy, state != 3'd0);
      chk("pulse_align", found | exhausted, done);
      if (busy) busy_cnt++;
      if (prev_cv && chunk_ready) begin
        chk("drop_valid", chunk_valid, 1'b0);
        last_pres = pres;
        if (prev_last) begin
          tested++;
          cur_idx = 0;
          last_acc_chunk = prev_chunk;
        end else begin
          cur_idx++;
        end
      end
      if (prev_cv && !chunk_ready) begin
        chk("hold_valid", chunk_valid, 1'b1);
        chk("hold_data", chunk_out, prev_chunk);
      end
      if (!mem_rd_n) begin
        reads++;
        chk("rd_addr", mem_addr, cur_idx);
      end
      if (chunk_valid && !prev_cv) begin
        exp_c = mem[cur_idx];
        if (cur_idx == m_nch - 1) exp_c[511:480] = m_start + tested;
        chk("chunk_data", chunk_out, exp_c);
        chk("chunk_last", chunk_last, cur_idx == m_nch - 1);
        pres = 0;
      end
      if (chunk_valid) pres++;
      if (found) found_cnt++;
      if (done) begin
        chk("done_armed", armed, 1'b1);
        chk("res_found", found, m_found);
        chk("res_exh", exhausted, m_exh);
        chk("res_nonce", nonce_out, m_nonce);
        chk("res_tested", tested, m_count);
        last_found = found;
        last_exh   = exhausted;
        last_nonce = nonce_out;
        done_seen  = 1'b1;
        armed      = 1'b0;
      end
      prev_cv    = chunk_valid;
      prev_chunk = chunk_out;
      prev_last  = chunk_last;
    end
  end

  task automatic start_search(input logic [31:0] s, input logic [31:0] e,
                              input int nch, input int diff, input int hm,
                              input logic [31:0] hn, input int rd,
                              input int hd, input bit with_abort);
    @(negedge clock);
    hit_mode = hm;
    hit_n = hn;
    rdy_delay = rd;
    hash_delay = hd;
    m_start = s;
    m_nch = (nch == 0) ? 1 : nch;
    m_found = 1'b0;
    m_exh = 1'b0;
    m_count = 0;
    if (s > e) begin
      m_exh = 1'b1;
      m_nonce = s;
    end else begin
      for (longint n = longint'(s); n <= longint'(e); n++) begin
        m_count++;
        if (is_hit(hashf(n[31:0]), diff)) begin
          m_found = 1'b1;
          m_nonce = n[31:0];
          break;
        end
      end
      if (!m_found) begin
        m_exh = 1'b1;
        m_nonce = e;
      end
    end
    tested = 0; cur_idx = 0; reads = 0; found_cnt = 0;
    busy_cnt = 0; done_seen = 1'b0; armed = 1'b1;
    nonce_start = s;
    nonce_end = e;
    n_chunks = 16'(nch);
    difficulty = 9'(diff);
    start = 1'b1;
    abort = with_abort;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    nonce_start = ~s;
    nonce_end = ~e;
    n_chunks = 16'(nch + 3);
    difficulty = 9'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (!done_seen && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk(name, done_seen, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, 3'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rd_n"}, mem_rd_n, 1'b1);
    chk({tag, "_addr"}, mem_addr, 16'd0);
    chk({tag, "_chunk"}, chunk_out, 512'd0);
    chk({tag, "_cvalid"}, chunk_valid, 1'b0);
    chk({tag, "_clast"}, chunk_last, 1'b0);
    chk({tag, "_found"}, found, 1'b0);
    chk({tag, "_exh"}, exhausted, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_nonce"}, nonce_out, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 16; w++)
        mem[i][w*32 +: 32] = 32'hC0DE0000 + 32'(i) * 32'h1000 + 32'(w) * 32'h11;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0; n_chunks = '0; difficulty = '0;
    hit_mode = 0; hit_n = '0; rdy_delay = 0; hash_delay = 0;
    armed = 1'b0; done_seen = 1'b0;
    m_nch = 1; m_start = '0; tested = 0; cur_idx = 0; reads = 0;
    found_cnt = 0; busy_cnt = 0; pres = 0; last_pres = 0;
    #12;
    check_reset_vals("rst");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 2 chunks, 5..9, hit on 7; a start while busy is ignored
    start_search(32'd5, 32'd9, 2, 10, 1, 32'd7, 0, 2, 1'b0);
    repeat (3) @(negedge clock);
    nonce_start = 32'd0; nonce_end = 32'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("s1_done", 300);
    chk("s1_found", last_found, 1'b1);
    chk("s1_nonce", last_nonce, 32'd7);
    chk("s1_tested", tested, 3);
    chk("s1_reads", reads, 6);

    // 0..3 with no hit
    start_search(32'd0, 32'd3, 1, 10, 0, 32'd0, 0, 0, 1'b0);
    wait_done("s2_done", 300);
    chk("s2_exh", last_exh, 1'b1);
    chk("s2_nonce", last_nonce, 32'd3);
    chk("s2_found_cnt", found_cnt, 0);
    chk("s2_tested", tested, 4);
    chk("s2_cycles", busy_cnt, 21);

    // ready held low for 4 cycles per chunk
    start_search(32'h12345678, 32'h12345678, 2, 0, 0, 32'd0, 4, 1, 1'b0);
    wait_done("s3_done", 300);
    chk("s3_pres", last_pres, 5);
    chk("s3_field", last_acc_chunk[511:480], 32'h12345678);
    chk("s3_nonce", last_nonce, 32'h12345678);

    // abort while waiting for a slow hash; the late digest is stray
    start_search(32'd20, 32'd30, 1, 10, 0, 32'd0, 0, 30, 1'b0);
    begin
      int c = 0;
      while (state !== 3'd4 && c < 200) begin
        @(negedge clock);
        c++;
      end
    end
    chk("s4_in_wait", state, 3'd4);
    abort = 1'b1;
    armed = 1'b0;
    @(posedge clock);
    #1;
    chk("s4_idle", state, 3'd0);
    chk("s4_cvalid", chunk_valid, 1'b0);
    chk("s4_rd_n", mem_rd_n, 1'b1);
    chk("s4_done", done, 1'b0);
    @(negedge clock);
    abort = 1'b0;
    begin
      int c = 0;
      while (!hash_valid && c < 60) begin
        @(posedge clock);
        c++;
      end
    end
    chk("s4_stray", hash_valid, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("s4_still_idle", state, 3'd0);
    start_search(32'd0, 32'd0, 1, 0, 0, 32'd0, 0, 0, 1'b1);
    wait_done("s4_restart", 300);
    chk("s4_re_found", last_found, 1'b1);

    // asynchronous reset in the middle of a fetch cycle
    start_search(32'd40, 32'd50, 3, 10, 0, 32'd0, 0, 0, 1'b0);
    begin
      int c = 0;
      do begin
        @(posedge clock);
        #1;
        c++;
      end while (state !== 3'd1 && c < 100);
    end
    chk("s5_in_fetch", state, 3'd1);
    #2;
    reset = 1'b0;
    armed = 1'b0;
    #1;
    check_reset_vals("s5");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("s5_wait_idle", state, 3'd0);

    // single nonce at the top of the range, n_chunks 0 means 1
    start_search(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 10, 0, 32'd0, 0, 0, 1'b0);
    wait_done("s6_done", 300);
    chk("s6_exh", last_exh, 1'b1);
    chk("s6_nonce", last_nonce, 32'hFFFFFFFF);
    chk("s6_tested", tested, 1);
    chk("s6_reads", reads, 1);

    // inverted range finishes with no memory read
    start_search(32'd10, 32'd2, 1, 10, 0, 32'd0, 0, 0, 1'b0);
    wait_done("s7_done", 50);
    chk("s7_exh", last_exh, 1'b1);
    chk("s7_reads", reads, 0);
    chk("s7_nonce", last_nonce, 32'd10);

    // difficulty beyond the hash width needs an all-zero digest
    start_search(32'd0, 32'd2, 1, 300, 2, 32'd1, 0, 0, 1'b0);
    wait_done("s8_done", 300);
    chk("s8_found", last_found, 1'b1);
    chk("s8_nonce", last_nonce, 32'd1);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mining_ctrl_param.md
MINING_CTRL_PARAM -- requirements
Module: mining_ctrl_param

Interface
REQ-001 Parameters SHALL be: CHUNK_W, default 512, chunk width in bits.
REQ-002 ADDR_W, default 16, chunk-memory address width.
REQ-003 NONCE_W, default 32, nonce width.
REQ-004 HASH_W, default 256, digest width.
REQ-005 NONCE_POS, default 511, MSB bit index of the nonce field in the last chunk.
REQ-006 DIFF_W, default 9, width of the difficulty input.
REQ-007 One clock; reset is asynchronous and active-low. Ports SHALL be:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- start  in  1  begin a search; sampled in IDLE only.
- abort  in  1  cancel the search from any non-IDLE state.
- nonce_start  in  NONCE_W  first nonce, inclusive.
- nonce_end  in  NONCE_W  last nonce, inclusive.
- n_chunks  in  ADDR_W  chunks per message; 0 is treated as 1.
- difficulty  in  DIFF_W  required count of leading zero bits in the hash.
- mem_rd_data  in  CHUNK_W  chunk-memory read data, valid 1 cycle after mem_rd_n=0.
- chunk_ready  in  1  hash core accepts a chunk.
- hash_in  in  HASH_W  digest.
- hash_valid  in  1  digest valid; 1-cycle pulse.
- mem_addr  out  ADDR_W  chunk-memory address.
- mem_rd_n  out  1  active-low read strobe.
- chunk_out  out  CHUNK_W  chunk to the hash core.
- chunk_valid  out  1  chunk_out is valid.
- chunk_last  out  1  chunk_out is the final chunk of the message.
- busy  out  1  high in any state except IDLE.
- found  out  1  1-cycle pulse when a qualifying nonce is found.
- exhausted  out  1  1-cycle pulse when the range ends with no hit.
- done  out  1  1-cycle pulse at the end of any search that is not aborted.
- nonce_out  out  NONCE_W  nonce under test; frozen on found.
- state  out  3  FSM state encoding.

Function
REQ-008 FSM encoding SHALL be: IDLE=0, FETCH=1, LOAD=2, ISSUE=3, WAIT_HASH=4, CHECK=5, FINISH=6.
REQ-009 IDLE on start=1:
- latch nonce_start, nonce_end, n_chunks, difficulty into internal registers;
- nonce_out <= nonce_start; chunk index <= 0; go to FETCH.
- If nonce_start > nonce_end, go to FINISH with exhausted instead.
REQ-010 FETCH: mem_addr = chunk index, mem_rd_n = 0 for 1 cycle; go to LOAD.
REQ-011 LOAD: register mem_rd_data into chunk_out, then:
- if this is the last chunk (index == n_chunks-1), overwrite bits [NONCE_POS -: NONCE_W] with nonce_out;
- mem_rd_n = 1; go to ISSUE.
REQ-012 ISSUE:
- chunk_valid = 1; chunk_last = 1 on the last chunk only;
- chunk_out and chunk_valid stay stable until chunk_ready=1;
- on acceptance, go to WAIT_HASH if last, otherwise increment the index and go to FETCH.
REQ-013 WAIT_HASH: hold until hash_valid=1, register hash_in, then go to CHECK. hash_valid in any other state SHALL be ignored.
REQ-014 CHECK: a hit is defined as hash bits [HASH_W-1 -: difficulty] all zero.
- difficulty=0 is always a hit; difficulty >= HASH_W requires an all-zero hash.
- Hit: pulse found, freeze nonce_out, go to FINISH.
- No hit and nonce_out == nonce_end: pulse exhausted, go to FINISH.
- Otherwise: nonce_out <= nonce_out+1, chunk index <= 0, go to FETCH.
REQ-015 Nonce arithmetic SHALL be modulo 2^NONCE_W; nonce_end = all-ones SHALL terminate without wrapping to 0.
REQ-016 FINISH: pulse done for 1 cycle; return to IDLE. found/exhausted SHALL be asserted in the same cycle as done.
REQ-017 Throughput per nonce SHALL be 3*n_chunks + 2 cycles plus chunk_ready and hash_valid wait cycles.
REQ-018 abort=1 in any non-IDLE state SHALL, at the next edge:
- set state to IDLE;
- set chunk_valid=0 and mem_rd_n=1;
- pulse none of done, found, exhausted.
REQ-019 start while busy SHALL be ignored; abort and start together in IDLE SHALL start the search.
REQ-020 Input changes after the latch cycle SHALL NOT affect the running search.

Reset
REQ-021 reset=0 SHALL asynchronously set:
- state=IDLE; mem_rd_n=1; mem_addr=0;
- chunk_out=0; chunk_valid=0; chunk_last=0;
- found=0; exhausted=0; done=0; busy=0; nonce_out=0; internal registers 0.
REQ-022 Reset asserted mid-search SHALL discard the search; after release the block SHALL wait in IDLE for start.

Verification
REQ-023 Bench scenarios SHALL cover:
- n_chunks=2, range 5..9, difficulty=10, hash core returns a qualifying hash for nonce 7 -> found and done together, nonce_out=7, exactly 3 nonces tested.
- Range 0..3, no qualifying hash -> exhausted and done after the nonce 3 check, found never asserted, nonce_out=3.
- chunk_ready held low 4 cycles in ISSUE -> chunk_out/chunk_valid stable throughout, accepted on the first ready cycle, last-chunk field [511:480] equals the nonce.
- abort in WAIT_HASH, then a stray hash_valid -> IDLE next cycle, no done pulse, stray hash ignored; a new start then runs normally.
- Async reset mid-FETCH between clock edges -> all outputs at reset values immediately.
- Edge ranges: nonce_start=nonce_end=FFFFFFFF -> single test, no wrap; nonce_start=10, nonce_end=2 -> done+exhausted with no memory read.
